// File: rtl/eco32f_divider.sv
// eco32f_divider: iterative 32-step restoring divide/remainder unit for the
// execute stage. Signed operations are handled by dividing magnitudes and
// fixing the sign of the quotient or remainder when the result is stored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_op_div         divide instruction in execute
//   ex_op_rem         remainder instruction in execute (wins if both are set)
//   ex_signed_div     1 = signed, 0 = unsigned
//   ex_div_a/ex_div_b dividend / divisor
//   ex_flush          abort any operation, return to IDLE
//   ex_stall          downstream stall, holds the result in DONE
//   ex_div_stall      execute must hold while high
//   ex_div_valid      ex_div_result valid this cycle
//   ex_div_result     quotient or remainder
//   ex_exc_div_zero   divide-by-zero exception, coincident with ex_div_valid
//
// state | meaning
// IDLE  | waiting for a div/rem op; operands latched on start
// RUN   | one restoring step per cycle, 32 cycles
// DONE  | result presented; held while ex_stall
module eco32f_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_op_div,
  input  logic        ex_op_rem,
  input  logic        ex_signed_div,
  input  logic [31:0] ex_div_a,
  input  logic [31:0] ex_div_b,
  input  logic        ex_flush,
  input  logic        ex_stall,
  output logic        ex_div_stall,
  output logic        ex_div_valid,
  output logic [31:0] ex_div_result,
  output logic        ex_exc_div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;      // dividend bits shift out MSB-first, quotient shifts in
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [31:0] result_q;
  logic        mode_rem_q, quot_neg_q, rem_neg_q, zero_q;

  logic        start;
  logic        b_zero;
  logic [31:0] abs_a, abs_b;
  logic [32:0] p, diff;
  logic        ge;
  logic [31:0] rem_nxt, quot_nxt, res_nxt;

  assign start  = (ex_op_div | ex_op_rem) & (state_q == IDLE) & !ex_flush;
  assign b_zero = (ex_div_b == 32'd0);
  assign abs_a  = (ex_signed_div & ex_div_a[31]) ? (32'd0 - ex_div_a) : ex_div_a;
  assign abs_b  = (ex_signed_div & ex_div_b[31]) ? (32'd0 - ex_div_b) : ex_div_b;

  // Partial remainder is kept 33 bits wide during the compare so an unsigned
  // divisor above 2^31 cannot lose the top remainder bit on the shift.
  assign p        = {rem_q, dvd_q[31]};
  assign diff     = p - {1'b0, dvs_q};
  assign ge       = !diff[32];
  assign rem_nxt  = ge ? diff[31:0] : p[31:0];
  assign quot_nxt = {dvd_q[30:0], ge};
  assign res_nxt  = mode_rem_q ? (rem_neg_q  ? (32'd0 - rem_nxt)  : rem_nxt)
                               : (quot_neg_q ? (32'd0 - quot_nxt) : quot_nxt);

  assign ex_div_stall    = start | ((state_q == RUN) & !ex_flush);
  assign ex_div_valid    = (state_q == DONE);
  assign ex_exc_div_zero = (state_q == DONE) & zero_q;
  assign ex_div_result   = result_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = b_zero ? DONE : RUN;
      RUN:     if (cnt_q == 5'd0) state_d = DONE;
      DONE:    if (!ex_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ex_flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 32'd0;
      result_q   <= 32'd0;
      mode_rem_q <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_rem_q <= ex_op_rem;
            quot_neg_q <= ex_signed_div & (ex_div_a[31] ^ ex_div_b[31]);
            rem_neg_q  <= ex_signed_div & ex_div_a[31];
            dvd_q      <= abs_a;
            dvs_q      <= abs_b;
            rem_q      <= 32'd0;
            cnt_q      <= 5'd31;
            zero_q     <= b_zero;
            if (b_zero) result_q <= 32'd0;
          end
        end
        RUN: begin
          if (!ex_flush) begin
            rem_q <= rem_nxt;
            dvd_q <= quot_nxt;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) result_q <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eco32f_divider.sv
module tb_eco32f_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_op_div, ex_op_rem, ex_signed_div;
  logic [31:0] ex_div_a, ex_div_b;
  logic        ex_flush, ex_stall;
  logic        ex_div_stall, ex_div_valid, ex_exc_div_zero;
  logic [31:0] ex_div_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eco32f_divider dut (
    .clk            (clk),
    .rst            (rst),
    .ex_op_div      (ex_op_div),
    .ex_op_rem      (ex_op_rem),
    .ex_signed_div  (ex_signed_div),
    .ex_div_a       (ex_div_a),
    .ex_div_b       (ex_div_b),
    .ex_flush       (ex_flush),
    .ex_stall       (ex_stall),
    .ex_div_stall   (ex_div_stall),
    .ex_div_valid   (ex_div_valid),
    .ex_div_result  (ex_div_result),
    .ex_exc_div_zero(ex_exc_div_zero)
  );

  // Presents an op at the next negedge and keeps it asserted until the result
  // appears; counts stall cycles and cycles from issue to valid.
  task automatic do_op(input logic d, input logic r, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output int lat,
                       output logic [31:0] res, output logic zero, output logic done);
    @(negedge clk);
    ex_op_div = d; ex_op_rem = r; ex_signed_div = s; ex_div_a = a; ex_div_b = b;
    stalls = 0; lat = 0; done = 1'b0; res = 32'd0; zero = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (ex_div_valid) begin
        done = 1'b1; res = ex_div_result; zero = ex_exc_div_zero;
        ex_op_div = 1'b0; ex_op_rem = 1'b0;
      end else begin
        if (ex_div_stall) stalls++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_op_div = 0; ex_op_rem = 0; ex_signed_div = 0; ex_div_a = 0; ex_div_b = 0;
    ex_flush = 0; ex_stall = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ex_div_valid !== 1'b0 || ex_div_stall !== 1'b0 || ex_exc_div_zero !== 1'b0 ||
        ex_div_result !== 32'd0) begin
      errors++;
      $display("FAIL reset: valid=%b stall=%b zero=%b result=%h, required 0 0 0 00000000",
               ex_div_valid, ex_div_stall, ex_exc_div_zero, ex_div_result);
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    logic        vd [8], vr [8], vs [8];
    logic [31:0] va [8], vb [8], ve [8];
    int stalls, lat; logic [31:0] res; logic zero, done;
    vd[0]=1; vr[0]=0; vs[0]=0; va[0]=32'd100;        vb[0]=32'd7;          ve[0]=32'd14;
    vd[1]=0; vr[1]=1; vs[1]=0; va[1]=32'd100;        vb[1]=32'd7;          ve[1]=32'd2;
    vd[2]=1; vr[2]=0; vs[2]=1; va[2]=32'hFFFFFF9C;   vb[2]=32'd7;          ve[2]=32'hFFFFFFF2;
    vd[3]=0; vr[3]=1; vs[3]=1; va[3]=32'hFFFFFF9C;   vb[3]=32'd7;          ve[3]=32'hFFFFFFFE;
    vd[4]=0; vr[4]=1; vs[4]=1; va[4]=32'd100;        vb[4]=32'hFFFFFFF9;   ve[4]=32'd2;
    vd[5]=1; vr[5]=0; vs[5]=1; va[5]=32'h80000000;   vb[5]=32'hFFFFFFFF;   ve[5]=32'h80000000;
    vd[6]=0; vr[6]=1; vs[6]=1; va[6]=32'h80000000;   vb[6]=32'hFFFFFFFF;   ve[6]=32'd0;
    vd[7]=1; vr[7]=0; vs[7]=0; va[7]=32'hFFFFFFFF;   vb[7]=32'd1;          ve[7]=32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      do_op(vd[k], vr[k], vs[k], va[k], vb[k], stalls, lat, res, zero, done);
      checks++;
      if (!done || lat != 33 || stalls != 33) begin
        errors++;
        $display("FAIL arith_timing[%0d]: done=%b latency=%0d stalls=%0d, required 1 33 33",
                 k, done, lat, stalls);
      end
      checks++;
      if (res !== ve[k] || zero !== 1'b0) begin
        errors++;
        $display("FAIL arith_result[%0d]: result=%h zero=%b, required %h 0", k, res, zero, ve[k]);
      end
    end
  endtask

  task automatic test_div_zero();
    int stalls, lat; logic [31:0] res; logic zero, done;
    do_op(1'b1, 1'b0, 1'b0, 32'd5, 32'd0, stalls, lat, res, zero, done);
    checks++;
    if (!done || lat != 1 || stalls != 1) begin
      errors++;
      $display("FAIL div_zero_timing: done=%b latency=%0d stalls=%0d, required 1 1 1",
               done, lat, stalls);
    end
    checks++;
    if (res !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_result: result=%h zero=%b, required 00000000 1", res, zero);
    end
    @(negedge clk); #1;
    checks++;
    if (ex_div_valid !== 1'b0 || ex_exc_div_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_after: valid=%b zero=%b, required 0 0", ex_div_valid, ex_exc_div_zero);
    end
  endtask

  task automatic test_done_hold();
    int stalls, lat; logic [31:0] res; logic zero, done;
    bit seen = 0;
    @(negedge clk);
    ex_op_div = 1; ex_op_rem = 0; ex_signed_div = 0; ex_div_a = 32'd1000; ex_div_b = 32'd10;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (ex_div_valid) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_timeout: valid=0 after 40 cycles, required 1");
    end
    ex_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin ex_stall = 1'b0; ex_op_div = 1'b0; end
      #1;
      checks++;
      if (ex_div_valid !== 1'b1 || ex_div_result !== 32'd100 || ex_div_stall !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: valid=%b result=%h stall=%b, required 1 00000064 0",
                 k, ex_div_valid, ex_div_result, ex_div_stall);
      end
      if (k < 3) @(negedge clk);
    end
    do_op(1'b0, 1'b1, 1'b0, 32'd7, 32'd2, stalls, lat, res, zero, done);
    checks++;
    if (!done || lat != 33 || stalls != 33 || res !== 32'd1) begin
      errors++;
      $display("FAIL hold_next_op: done=%b latency=%0d stalls=%0d result=%h, required 1 33 33 00000001",
               done, lat, stalls, res);
    end
  endtask

  task automatic test_flush();
    int stalls, lat; logic [31:0] res; logic zero, done;
    bit bad = 0;
    @(negedge clk);
    ex_op_div = 1; ex_op_rem = 0; ex_signed_div = 0; ex_div_a = 32'd100; ex_div_b = 32'd7;
    repeat (10) @(negedge clk);
    ex_flush = 1'b1;
    #1;
    checks++;
    if (ex_div_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: stall=%b, required 0", ex_div_stall);
    end
    @(negedge clk);
    ex_flush = 1'b0; ex_op_div = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (ex_div_stall !== 1'b0 || ex_div_valid !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL flush_after: stall or valid seen high after flush, required both 0");
    end
    do_op(1'b1, 1'b0, 1'b0, 32'd9, 32'd3, stalls, lat, res, zero, done);
    checks++;
    if (!done || lat != 33 || stalls != 33 || res !== 32'd3) begin
      errors++;
      $display("FAIL flush_next_op: done=%b latency=%0d stalls=%0d result=%h, required 1 33 33 00000003",
               done, lat, stalls, res);
    end
  endtask

  task automatic test_flush_start();
    bit bad = 0;
    @(negedge clk);
    ex_op_div = 1; ex_signed_div = 0; ex_div_a = 32'd50; ex_div_b = 32'd0; ex_flush = 1'b1;
    #1;
    if (ex_div_stall !== 1'b0) bad = 1;
    @(negedge clk);
    ex_op_div = 1'b0; ex_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (ex_div_stall !== 1'b0 || ex_div_valid !== 1'b0 || ex_exc_div_zero !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL flush_start: op started despite flush, required no stall/valid/exception");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_op_rem = 1; ex_signed_div = 0; ex_div_a = 32'd77; ex_div_b = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1; ex_op_rem = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ex_div_stall !== 1'b0 || ex_div_valid !== 1'b0 || ex_div_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: stall=%b valid=%b result=%h, required 0 0 00000000",
               ex_div_stall, ex_div_valid, ex_div_result);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_done_hold();
    test_flush();
    test_flush_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
